// File: rtl/shift_add_multiply.sv
// Sequential radix-2 shift-and-add unsigned multiplier, one product bit per cycle.
// Shares the start/busy/finish handshake of the restoring divider.
//
// state | meaning
// IDLE  | waiting for start; product holds the last result
// CALC  | WIDTH add-and-shift iterations, busy high
module shift_add_multiply #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic                 finish
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     a_reg;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH:0]       sum;
   logic                 last;
   logic                 accept;

   assign last = (cnt == CW'(WIDTH - 1));

   // Upper half plus the gated multiplicand; bit WIDTH keeps the carry that the shift pulls down.
   assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = CALC;
               accept    = 1'b1;
            end
         end
         CALC: begin
            if (last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         a_reg  <= '0;
         acc    <= '0;
         finish <= 1'b0;
      end else begin
         finish <= 1'b0;
         if (accept) begin
            a_reg <= multiplicand;
            acc   <= {{WIDTH{1'b0}}, multiplier};
            cnt   <= '0;
         end else if (state == CALC) begin
            acc <= {sum, acc[WIDTH-1:1]};
            if (last) begin
               cnt    <= '0;
               finish <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   assign product = acc;
   assign busy    = (state == CALC);

endmodule

// File: tb/tb_shift_add_multiply.sv
// Scoreboard bench for shift_add_multiply (WIDTH=8): expected products are queued
// when start is driven and popped when finish is seen.
module tb_shift_add_multiply;

   localparam int W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [W-1:0]     a = '0;
   logic [W-1:0]     b = '0;
   logic [2*W-1:0]   product;
   logic             busy;
   logic             finish;

   int               n_cmp = 0;
   int               n_bad = 0;
   logic [2*W-1:0]   exp_q[$];

   always #5 clk = ~clk;

   shift_add_multiply #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (a),
      .multiplier   (b),
      .product      (product),
      .busy         (busy),
      .finish       (finish)
   );

   // Called at a negedge: start is sampled at the following rising edge.
   task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] e;
      e = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      a = x;
      b = y;
      start = 1'b1;
      exp_q.push_back(e);
   endtask

   // Advances negedge by negedge after an accept edge until finish or a budget expires.
   task automatic wait_finish(input bit drop, output int lat, output int busy_bad);
      lat = 0;
      busy_bad = 0;
      do begin
         @(negedge clk);
         lat++;
         if (drop && lat == 1) start = 1'b0;
         if (!finish && !busy) busy_bad++;
         if (finish && busy) busy_bad++;
      end while (!finish && lat < 40);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_start(8'd5, 8'd5);
      void'(exp_q.pop_back());
      repeat (2) @(negedge clk);
      n_cmp++;
      if (product !== 16'h0000) begin
         n_bad++; $display("FAIL reset_product: got %h want 0000", product);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      n_cmp++;
      if (finish !== 1'b0) begin
         n_bad++; $display("FAIL reset_finish: got %b want 0", finish);
      end
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL post_reset_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_products();
      logic [W-1:0]   ta[10];
      logic [W-1:0]   tb_[10];
      logic [2*W-1:0] e;
      int lat, bb;
      ta  = '{8'd13, 8'd255, 8'd255, 8'd1,   8'd0,   8'd200, 8'd0, 8'd0, 8'd0, 8'd0};
      tb_ = '{8'd11, 8'd255, 8'd1,   8'd255, 8'd200, 8'd0,   8'd0, 8'd0, 8'd0, 8'd0};
      for (int i = 6; i < 10; i++) begin
         ta[i]  = W'($urandom_range(0, 255));
         tb_[i] = W'($urandom_range(0, 255));
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive_start(ta[i], tb_[i]);
         wait_finish(1'b1, lat, bb);
         n_cmp++;
         if (lat !== 9) begin
            n_bad++; $display("FAIL mul_latency[%0d]: got %0d want 9", i, lat);
         end
         n_cmp++;
         if (bb !== 0) begin
            n_bad++; $display("FAIL mul_busy[%0d]: %0d bad busy cycles want 0", i, bb);
         end
         e = '0;
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL mul_queue[%0d]: got empty want entry", i);
         end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (product !== e) begin
               n_bad++; $display("FAIL mul_product[%0d] %0d*%0d: got %h want %h", i, ta[i], tb_[i], product, e);
            end
         end
         @(negedge clk);
         n_cmp++;
         if (finish !== 1'b0) begin
            n_bad++; $display("FAIL finish_pulse[%0d]: got %b want 0", i, finish);
         end
         n_cmp++;
         if (product !== e) begin
            n_bad++; $display("FAIL product_hold[%0d]: got %h want %h", i, product, e);
         end
      end
   endtask

   task automatic test_ignore_busy();
      int lat, extra;
      logic [2*W-1:0] e;
      @(negedge clk);
      drive_start(8'd7, 8'd9);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) start = 1'b0;
         if (lat == 4) begin a = 8'd3; b = 8'd3; start = 1'b1; end
         if (lat == 5) start = 1'b0;
      end while (!finish && lat < 40);
      n_cmp++;
      if (lat !== 9) begin
         n_bad++; $display("FAIL ignore_latency: got %0d want 9", lat);
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++;
      if (product !== e) begin
         n_bad++; $display("FAIL ignore_product: got %h want %h", product, e);
      end
      extra = 0;
      repeat (15) begin
         @(negedge clk);
         if (finish || busy) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin
         n_bad++; $display("FAIL ignore_second_op: got %0d active cycles want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bb, extra;
      logic [2*W-1:0] e;
      @(negedge clk);
      drive_start(8'd2, 8'd3);
      wait_finish(1'b0, lat, bb);
      n_cmp++;
      if (lat !== 9 || bb !== 0) begin
         n_bad++; $display("FAIL b2b_first_timing: got lat %0d badbusy %0d want 9/0", lat, bb);
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++;
      if (product !== e) begin
         n_bad++; $display("FAIL b2b_first_product: got %h want %h", product, e);
      end
      drive_start(8'd5, 8'd6);
      wait_finish(1'b1, lat, bb);
      n_cmp++;
      if (lat !== 9 || bb !== 0) begin
         n_bad++; $display("FAIL b2b_second_timing: got lat %0d badbusy %0d want 9/0", lat, bb);
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++;
      if (product !== e) begin
         n_bad++; $display("FAIL b2b_second_product: got %h want %h", product, e);
      end
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (finish) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin
         n_bad++; $display("FAIL b2b_extra_finish: got %0d want 0", extra);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bb, extra;
      logic [2*W-1:0] e;
      @(negedge clk);
      a = 8'd50; b = 8'd60; start = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++;
      if (product !== 16'h0000 || busy !== 1'b0 || finish !== 1'b0) begin
         n_bad++; $display("FAIL abort_state: got p=%h busy=%b fin=%b want 0000/0/0", product, busy, finish);
      end
      extra = 0;
      repeat (15) begin
         @(negedge clk);
         if (finish || busy) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin
         n_bad++; $display("FAIL abort_no_finish: got %0d active cycles want 0", extra);
      end
      drive_start(8'd100, 8'd100);
      wait_finish(1'b1, lat, bb);
      n_cmp++;
      if (lat !== 9 || bb !== 0) begin
         n_bad++; $display("FAIL after_abort_timing: got lat %0d badbusy %0d want 9/0", lat, bb);
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++;
      if (product !== e) begin
         n_bad++; $display("FAIL after_abort_product: got %h want %h", product, e);
      end
   endtask

   initial begin
      test_reset();
      test_products();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shift_add_multiply.md
Name: shift_add_multiply

Overview:
Sequential radix-2 shift-and-add unsigned multiplier. It is the multiplicative counterpart to the team's restoring divider and uses the same start/finish handshake. It computes a 2*WIDTH-bit product at a fixed one bit per cycle, so latency does not depend on operand values. It feeds the modular-exponentiation datapath, where a multiply is followed by a divide (remainder) step.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
start  input  1  request; sampled only while idle.
multiplicand  input  WIDTH  operand A, unsigned; captured on accepted start.
multiplier  input  WIDTH  operand B, unsigned; captured on accepted start.
product  output  2*WIDTH  A*B; valid from finish assertion until next accepted start.
busy  output  1  high while in CALC.
finish  output  1  one-cycle pulse marking product valid.

Behaviour:
- Reset: rst_n low at a rising edge sets state=IDLE, cnt=0, operand regs=0, accumulator=0, finish=0. Reset values: product=0, busy=0, finish=0. Reset mid-CALC aborts the operation, and no finish is produced.
- States: IDLE, CALC.
  - IDLE -> CALC when start=1 at an edge.
  - CALC -> IDLE at the edge where cnt==WIDTH-1.
- Accept: start=1 in IDLE at edge k has the following effects:
  - multiplicand is latched into a_reg.
  - acc[2*WIDTH-1:WIDTH] is set to 0 and acc[WIDTH-1:0] to multiplier.
  - cnt is set to 0.
  - busy=1 from cycle k+1.
- Iteration, at each CALC edge:
  - sum is the (WIDTH+1)-bit value acc[2*WIDTH-1:WIDTH] + (acc[0] ? a_reg : 0), with carry kept in bit WIDTH.
  - acc is updated to {sum, acc[WIDTH-1:1]}, i.e. a logical right shift of {sum, lower half}.
  - The carry must never be lost; internal add width is WIDTH+1.
- Count: cnt increments each CALC edge. At the edge where cnt==WIDTH-1:
  - cnt is set to 0.
  - state goes to IDLE.
  - finish is registered to 1.
- Latency: accept at edge k, WIDTH iterations at edges k+1..k+WIDTH. finish=1 and busy=0 during the cycle after edge k+WIDTH. finish is high for exactly 1 cycle.
- product = acc, driven directly from the register. It holds after finish until the next accepted start, which overwrites it. In IDLE without start the accumulator is not cleared.
- Handshake rules:
  - start while busy=1 is ignored; operands and progress are unaffected.
  - start held high continuously is re-accepted on the first IDLE edge.
  - start during the finish cycle is accepted, giving back-to-back operation with a throughput of one result per WIDTH+1 cycles.
  - Operand inputs may change freely after the accept edge.
- Arithmetic: result is exact unsigned A*B < 2^(2*WIDTH), so no overflow is possible. Zero operands still take WIDTH iterations; there is no early termination, to keep timing constant.
- Reset priority: rst_n low overrides start and any in-flight state on the same edge.

Test Plan:
- WIDTH=8, A=13, B=11, start pulse at edge k -> busy=1 for cycles k+1..k+8; finish=1 only in cycle k+9; product=16'h008F.
- A=255, B=255 -> product=16'hFE01 (carry path exercised); A=255, B=1 -> 16'h00FF; A=1, B=255 -> 16'h00FF.
- A=0, B=200 and A=200, B=0 -> product=0; finish still exactly 8 cycles after accept.
- Accept A=7, B=9, then pulse start with A=3, B=3 at edge k+4 -> ignored; product=63 at finish; no second finish.
- start held high with A=2, B=3, then A=5, B=6 applied during finish cycle -> product=6 in first finish cycle, product=30 nine cycles later; finish pulses 9 cycles apart.
- rst_n low for one edge at k+5 mid-operation -> product=0, busy=0, finish never asserts; a new start afterwards with A=100, B=100 -> product=16'h2710.
